// File: rtl/tlb_pkg.sv
// Shared types and constants for the tlb_fetch address-translation stage.
package tlb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int          PTE_VLD_BIT = 15;
  localparam logic [15:0] PT_BASE_DEF = 16'h0100;

  function automatic int pfn_width(input int page_bits);
    return 16 - page_bits;
  endfunction

endpackage

// File: rtl/tlb_cam.sv
// Fully-associative TLB entry array: parallel VPN match plus one write port.
// Flush has priority over a same-edge write, so a racing fill is dropped.
module tlb_cam
  import tlb_pkg::*;
#(
  parameter int ENTRIES = 4,
  parameter int VPN_W   = 8,
  parameter int PFN_W   = 8,
  parameter int IDX_W   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [VPN_W-1:0]   lookup_vpn,
  output logic [ENTRIES-1:0] hit_vec,
  output logic [PFN_W-1:0]   hit_pfn,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [VPN_W-1:0]   wr_vpn,
  input  logic [PFN_W-1:0]   wr_pfn
);

  logic [ENTRIES-1:0] valid;
  logic [VPN_W-1:0]   tag [ENTRIES];
  logic [PFN_W-1:0]   pfn [ENTRIES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
    end else if (flush) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag[wr_idx] <= wr_vpn;
      pfn[wr_idx] <= wr_pfn;
    end
  end

  // Entries are never duplicated, so an OR of the matching PFNs is a clean mux.
  always_comb begin
    hit_vec = '0;
    hit_pfn = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid[i] && (tag[i] == lookup_vpn)) begin
        hit_vec[i] = 1'b1;
        hit_pfn    = hit_pfn | pfn[i];
      end
    end
  end

endmodule

// File: rtl/tlb_fetch.sv
// Virtual-to-physical translation with a small TLB and hardware page-table walk.
// Optional TLB_STATS_EN adds saturating hit_count / miss_count outputs.
module tlb_fetch
  import tlb_pkg::*;
#(
  parameter int          PAGE_BITS = 8,
  parameter int          ENTRIES   = 4,
  parameter logic [15:0] PT_BASE   = PT_BASE_DEF
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        req_valid,
  input  logic [15:0] enderecoVirtual,
  input  logic        flush,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [15:0] enderecoFisico,
  output logic        fault,
  output logic        pt_rd,
  output logic [15:0] pt_addr,
  input  logic [15:0] pt_data,
  input  logic        pt_ack
`ifdef TLB_STATS_EN
  ,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
`endif
);

  localparam int VPN_W = 16 - PAGE_BITS;
  localparam int PFN_W = pfn_width(PAGE_BITS);
  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  state_t               state, state_nxt;
  logic [IDX_W-1:0]     ptr;
  logic [VPN_W-1:0]     vpn_q;
  logic [PAGE_BITS-1:0] off_q;
  logic                 flushed;
  logic [ENTRIES-1:0]   hit_vec;
  logic [PFN_W-1:0]     hit_pfn;
  logic [VPN_W-1:0]     req_vpn;
  logic [PAGE_BITS-1:0] req_off;
  logic [PFN_W-1:0]     pte_pfn;
  logic                 accept, hit, ack, pte_ok, fill;
  logic                 unused_pte;

  assign req_vpn    = enderecoVirtual[15:PAGE_BITS];
  assign req_off    = enderecoVirtual[PAGE_BITS-1:0];
  assign pte_pfn    = pt_data[PFN_W-1:0];
  assign pte_ok     = pt_data[PTE_VLD_BIT];
  assign unused_pte = ^pt_data;
  assign accept     = (state == IDLE) && req_valid;
  assign hit        = |hit_vec;
  assign ack        = (state == WALK) && pt_ack;
  // A flush seen at any point of the walk cancels its fill.
  assign fill       = ack && pte_ok && !flushed;

  tlb_cam #(
    .ENTRIES (ENTRIES),
    .VPN_W   (VPN_W),
    .PFN_W   (PFN_W),
    .IDX_W   (IDX_W)
  ) u_cam (
    .clk        (Clock),
    .rst        (Resetn),
    .flush      (flush),
    .lookup_vpn (req_vpn),
    .hit_vec    (hit_vec),
    .hit_pfn    (hit_pfn),
    .wr_en      (fill),
    .wr_idx     (ptr),
    .wr_vpn     (vpn_q),
    .wr_pfn     (pte_pfn)
  );

  always_ff @(posedge Clock or posedge Resetn) begin
    if (Resetn) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      pt_rd      <= 1'b0;
    end else begin
      state      <= state_nxt;
      resp_valid <= (state_nxt == RESP);
      pt_rd      <= (state_nxt == WALK);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = hit ? RESP : WALK;
      WALK:    if (pt_ack) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE);
  end

  always_ff @(posedge Clock or posedge Resetn) begin
    if (Resetn) begin
      pt_addr        <= '0;
      enderecoFisico <= '0;
      fault          <= 1'b0;
      flushed        <= 1'b0;
    end else begin
      if (accept) begin
        flushed <= 1'b0;
        if (hit) begin
          enderecoFisico <= {hit_pfn, req_off};
          fault          <= 1'b0;
        end else begin
          pt_addr <= PT_BASE + 16'(req_vpn);
        end
      end else if ((state == WALK) && flush) begin
        flushed <= 1'b1;
      end
      if (ack) begin
        if (pte_ok) begin
          enderecoFisico <= {pte_pfn, off_q};
          fault          <= 1'b0;
        end else begin
          enderecoFisico <= '0;
          fault          <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clock or posedge Resetn) begin
    if (Resetn) begin
      ptr <= '0;
    end else if (flush) begin
      ptr <= '0;
    end else if (fill) begin
      ptr <= (ptr == IDX_W'(ENTRIES - 1)) ? '0 : ptr + IDX_W'(1);
    end
  end

  always_ff @(posedge Clock) begin
    if (accept) begin
      vpn_q <= req_vpn;
      off_q <= req_off;
    end
  end

`ifdef TLB_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge Clock or posedge Resetn) begin
    if (Resetn) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (accept) begin
      if (hit) hit_count  <= sat_inc(hit_count);
      else     miss_count <= sat_inc(miss_count);
    end
  end
`endif

endmodule

// File: tb/tb_tlb_fetch.sv
// Scoreboard bench for tlb_fetch: page-table responder, response monitor, directed scenarios.
module tb_tlb_fetch;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b1;
  logic        req_valid = 1'b0;
  logic [15:0] enderecoVirtual = '0;
  logic        flush = 1'b0;
  logic        req_ready, resp_valid, fault, pt_rd;
  logic [15:0] enderecoFisico, pt_addr;
  logic [15:0] pt_data = '0;
  logic        pt_ack = 1'b0;
`ifdef TLB_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  tlb_fetch dut (
    .Clock           (Clock),
    .Resetn          (Resetn),
    .req_valid       (req_valid),
    .enderecoVirtual (enderecoVirtual),
    .flush           (flush),
    .req_ready       (req_ready),
    .resp_valid      (resp_valid),
    .enderecoFisico  (enderecoFisico),
    .fault           (fault),
    .pt_rd           (pt_rd),
    .pt_addr         (pt_addr),
    .pt_data         (pt_data),
    .pt_ack          (pt_ack)
`ifdef TLB_STATS_EN
    ,
    .hit_count       (hit_count),
    .miss_count      (miss_count)
`endif
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [15:0] pa;
    logic        flt;
    logic        walk;
    int          lat;
    logic [15:0] pta;
  } exp_t;

  exp_t        sb[$];
  exp_t        e_mon;
  int          n_cmp = 0, n_err = 0;
  int          cyc = 0, acc_cyc = 0, n_resp = 0, rd_cnt = 0, ack_wait = 0, base = 0;
  logic        walked = 1'b0, addr_chk = 1'b0, stray = 1'b0, ack_now = 1'b0;
  logic [15:0] pt_mem [256];
  logic [15:0] idx;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Page-table responder and response monitor share the falling edge.
  initial begin
    forever begin
      @(negedge Clock);
      cyc++;
      ack_now = 1'b0;
      if (Resetn) begin
        rd_cnt = 0;
      end else begin
        if (pt_rd) begin
          if (rd_cnt == ack_wait) begin
            ack_now = 1'b1;
            idx     = pt_addr - 16'h0100;
            pt_data = pt_mem[idx[7:0]];
          end else begin
            rd_cnt++;
          end
        end else begin
          rd_cnt = 0;
        end
        if (req_valid && req_ready) begin
          acc_cyc  = cyc;
          walked   = 1'b0;
          addr_chk = 1'b0;
        end
        if (pt_rd) begin
          walked = 1'b1;
          if (!addr_chk && sb.size() > 0) begin
            check_val("pt_addr", pt_addr, sb[0].pta);
            addr_chk = 1'b1;
          end
        end
        if (resp_valid) begin
          n_resp++;
          if (sb.size() == 0) begin
            check_val("resp_unexpected", 1, 0);
          end else begin
            e_mon = sb.pop_front();
            check_val("pa", enderecoFisico, e_mon.pa);
            check_val("fault", fault, e_mon.flt);
            check_val("walked", walked, e_mon.walk);
            check_val("latency", cyc - acc_cyc, e_mon.lat);
          end
        end
      end
      pt_ack = ack_now | stray;
    end
  end

  task automatic send(input logic [15:0] va, input logic [15:0] pa, input logic flt,
                      input logic walk, input int lat);
    exp_t e;
    int   n = 0;
    while (!req_ready && n < 100) begin
      @(posedge Clock); #1;
      n++;
    end
    e.pa   = pa;
    e.flt  = flt;
    e.walk = walk;
    e.lat  = lat;
    e.pta  = 16'h0100 + {8'h00, va[15:8]};
    sb.push_back(e);
    req_valid       = 1'b1;
    enderecoVirtual = va;
    @(posedge Clock); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || !req_ready) && n < 200) begin
      @(posedge Clock); #1;
      n++;
    end
    if (n >= 200) begin
      check_val("resp_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic miss(input logic [15:0] va, input logic [15:0] pa, input int w);
    ack_wait = w;
    send(va, pa, 1'b0, 1'b1, 2 + w);
    wait_idle();
  endtask

  task automatic hit(input logic [15:0] va, input logic [15:0] pa);
    send(va, pa, 1'b0, 1'b0, 1);
    wait_idle();
  endtask

  task automatic fault_req(input logic [15:0] va, input int w);
    ack_wait = w;
    send(va, 16'h0000, 1'b1, 1'b1, 2 + w);
    wait_idle();
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge Clock); #1;
    flush = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) pt_mem[i] = 16'h0000;
    pt_mem[1] = 16'h8041;
    pt_mem[2] = 16'h8005;
    pt_mem[3] = 16'h8043;
    pt_mem[4] = 16'h8044;
    pt_mem[5] = 16'h8045;
    pt_mem[9] = 16'h8049;

    repeat (3) @(posedge Clock);
    #1;
    check_val("rst_req_ready", req_ready, 1);
    check_val("rst_resp_valid", resp_valid, 0);
    check_val("rst_pt_rd", pt_rd, 0);
    check_val("rst_pt_addr", pt_addr, 0);
    check_val("rst_pa", enderecoFisico, 0);
    check_val("rst_fault", fault, 0);
    Resetn = 1'b0;
    @(posedge Clock); #1;

    miss(16'h0234, 16'h0534, 3);
    hit(16'h02FF, 16'h05FF);
    fault_req(16'h0710, 0);
    fault_req(16'h0710, 2);

    // Round-robin replacement from a clean, flushed array.
    pulse_flush();
    miss(16'h0111, 16'h4111, 0);
    miss(16'h0222, 16'h0522, 1);
    miss(16'h0333, 16'h4333, 0);
    miss(16'h0444, 16'h4444, 2);
    miss(16'h0555, 16'h4555, 0);
    hit(16'h02AB, 16'h05AB);
    hit(16'h03CD, 16'h43CD);
    hit(16'h04EF, 16'h44EF);
    hit(16'h0501, 16'h4501);
    miss(16'h0100, 16'h4100, 0);

    // Flush in the middle of a walk.
    ack_wait = 4;
    send(16'h0234, 16'h0534, 1'b0, 1'b1, 6);
    @(posedge Clock); #1;
    pulse_flush();
    wait_idle();
    miss(16'h0234, 16'h0534, 0);
    hit(16'h02FF, 16'h05FF);

    // Flush on the same edge as the ack.
    ack_wait = 2;
    send(16'h0933, 16'h4933, 1'b0, 1'b1, 4);
    @(posedge Clock); #1;
    @(posedge Clock); #1;
    pulse_flush();
    wait_idle();
    miss(16'h0933, 16'h4933, 1);
    hit(16'h0934, 16'h4934);

    // Reset during a walk, then a stray ack.
    ack_wait = 20;
    send(16'h0333, 16'h4333, 1'b0, 1'b1, 22);
    @(posedge Clock); #1;
    @(posedge Clock); #1;
    check_val("walk_pt_rd", pt_rd, 1);
    Resetn = 1'b1;
    #1;
    check_val("midrst_pt_rd", pt_rd, 0);
    check_val("midrst_req_ready", req_ready, 1);
    check_val("midrst_pt_addr", pt_addr, 0);
    sb.delete();
    @(posedge Clock); #1;
    Resetn = 1'b0;
    base  = n_resp;
    stray = 1'b1;
    @(posedge Clock); #1;
    stray = 1'b0;
    repeat (5) @(posedge Clock);
    #1;
    check_val("stray_resp", n_resp - base, 0);
    check_val("post_rst_req_ready", req_ready, 1);
    miss(16'h0934, 16'h4934, 0);
    miss(16'h0234, 16'h0534, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
